de1_soc_qsys_cpu_debug_host_seq: RTL and testbench
==================================================

# de1_soc_qsys_cpu_debug_host_seq

Host-side sequencer for the Nios II debug slave's virtual-JTAG interface: drives the same signal set the debug slave consumes (tck, tdi, ir_in, uir/cdr/sdr/udr/rti strobes) and samples its tdo. It accepts one command at a time, performs an optional IR update and then one full DR scan (capture, shift, update). It returns the captured DR contents. It sits in simulation benches and in on-chip debug-master builds in place of the sld_virtual_jtag_basic hub, and connects port-for-port to the debug slave wrapper's vji_* nets.

## Interface
Parameters:
- DR_LEN, 38: DR scan length in tck cycles (2..64).
- TCK_HALF, 1: clk cycles per tck half-period (1..255).

Ports:
- clk  in  1  system clock; every register in the block is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer idle and able to accept a command.
- cmd_ir_en  in  1  1: perform an IR update before the DR scan.
- cmd_ir  in  2  IR value for the update.
- cmd_data  in  DR_LEN  DR value shifted out, LSB first.
- rsp_valid  out  1  response holds data.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DR_LEN  captured tdo bits; first bit shifted lands in bit 0.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to the target.
- vji_tdo  in  1  serial data from the target.
- vji_ir_in  out  2  current IR value.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RESP.
- Transitions:
  - IDLE→UIR on accept when cmd_ir_en=1.
  - IDLE→CDR on accept when cmd_ir_en=0.
  - UIR→CDR after 1 tck period.
  - CDR→SDR after 1 tck period.
  - SDR→UDR after DR_LEN tck periods.
  - UDR→RESP after 1 tck period.
  - RESP→IDLE when rsp_ready=1.
- Accept: cmd_valid & cmd_ready. cmd_ready=1 only in IDLE. On accept, latch cmd_data into the shift register; if cmd_ir_en=1, latch cmd_ir.
- vji_ir_in:
  - Loads cmd_ir at the start of UIR.
  - Otherwise holds its last value, including across commands; a command with cmd_ir_en=0 reuses the previous IR.
- Strobes:
  - Exactly one of uir/cdr/sdr/udr is high during its state, for the whole state.
  - vji_rti=1 in IDLE and RESP only.
- Shifting during SDR:
  - vji_tdi = shift[0].
  - On each tck rising edge, sample vji_tdo into the capture register at bit DR_LEN-1 and shift the capture register right.
  - On each tck falling edge, shift the out register right.
- rsp_data: updated only on the transition into RESP; stable while rsp_valid=1.
- tck generation: a half-period counter runs only outside IDLE and RESP; vji_tck=0 in IDLE and RESP.

## Timing
- Reset values:
  - cmd_ready=1, vji_rti=1.
  - rsp_valid=0, rsp_data=0, vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - All other strobes 0; state=IDLE.
- Every tck period starts low: TCK_HALF clk low, then TCK_HALF clk high.
- All strobe, tdi and ir_in changes occur on a clk edge coinciding with a tck falling edge or the period start. Nothing changes while tck is high.
- cmd_ready drops in the clk cycle after accept. The first state begins in that same cycle.
- Latency from the accept edge to rsp_valid=1:
  - (DR_LEN+3)·2·TCK_HALF + 1 clk with IR update.
  - (DR_LEN+2)·2·TCK_HALF + 1 clk without.
  - Defaults: 83 and 81.
- Response handshake:
  - rsp_valid stays high until a clk with rsp_ready=1.
  - rsp_valid and vji_rti=1 hold in RESP; cmd_ready rises in the cycle after the handshake.
- Back-to-back commands: minimum 1 IDLE clk between the response handshake and the next accept.
- cmd_valid while busy is ignored; no queueing.
- Reset asserted mid-scan:
  - All outputs take their reset values immediately (asynchronously).
  - The partial scan is discarded and no response is produced.
- rsp_ready=1 outside RESP: no effect.

## Test plan
- Reset: hold reset_n=0 for 3 clk, then release → cmd_ready=1, vji_rti=1, vji_tck=0, rsp_valid=0, vji_ir_in=0.
- IR + DR loopback (tdo tied to tdi, delayed one tck period), TCK_HALF=1:
  - Stimulus: cmd_ir_en=1, cmd_ir=2'b10, cmd_data=38'h2A_5A5A_5A5A.
  - Required: vji_uir high 2 clk with vji_ir_in=2'b10, then cdr 2 clk, sdr 76 clk, udr 2 clk.
  - Required: rsp_valid at accept+83; rsp_data equals cmd_data shifted by the loopback delay.
- No-IR command:
  - Stimulus: cmd_ir_en=0 after the previous test.
  - Required: no uir pulse, vji_ir_in stays 2'b10, rsp_valid at accept+81.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 clk; assert cmd_valid during that time.
  - Required: rsp_data stable, cmd_ready=0, no tck edges; after the handshake, cmd_ready=1 one clk later.
- TCK_HALF=3:
  - Required: each tck phase is 3 clk; vji_tdi never changes while vji_tck=1; latency is 247 clk with the IR update.
- Mid-scan reset:
  - Stimulus: assert reset_n=0 at SDR bit 10.
  - Required: the same cycle shows vji_sdr=0, vji_tck=0, vji_rti=1; after release, no rsp_valid appears and a new command completes normally.

Source files
------------

// File: rtl/de1_soc_qsys_cpu_debug_host_seq_if.sv
// de1_soc_qsys_cpu_debug_host_seq_if: command/response handshake and virtual-JTAG nets of the debug host sequencer
interface de1_soc_qsys_cpu_debug_host_seq_if #(
    parameter int DR_LEN = 38
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ir_en;
    logic [1:0]        cmd_ir;
    logic [DR_LEN-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DR_LEN-1:0] rsp_data;
    logic              vji_tck;
    logic              vji_tdi;
    logic              vji_tdo;
    logic [1:0]        vji_ir_in;
    logic              vji_uir;
    logic              vji_cdr;
    logic              vji_sdr;
    logic              vji_udr;
    logic              vji_rti;

    modport master (
        output cmd_valid, cmd_ir_en, cmd_ir, cmd_data, rsp_ready, vji_tdo,
        input  cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        input  cmd_valid, cmd_ir_en, cmd_ir, cmd_data, rsp_ready, vji_tdo,
        output cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/de1_soc_qsys_cpu_debug_host_seq.sv
// de1_soc_qsys_cpu_debug_host_seq: runs one optional IR update plus one full DR scan per command
// on the virtual-JTAG nets of the Nios II debug slave and returns the captured tdo bits.
module de1_soc_qsys_cpu_debug_host_seq #(
    parameter int DR_LEN   = 38,
    parameter int TCK_HALF = 1
) (
    input logic clk,
    input logic reset_n,
    de1_soc_qsys_cpu_debug_host_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;

    localparam int HW = TCK_HALF > 1 ? $clog2(TCK_HALF) : 1;
    localparam int BW = $clog2(DR_LEN);

    state_t            state_q, state_d;
    logic [HW-1:0]     half_q, half_d;
    logic              tck_q, tck_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DR_LEN-1:0] shift_q, shift_d;
    logic [DR_LEN-1:0] cap_q, cap_d;
    logic [DR_LEN-1:0] rsp_q, rsp_d;
    logic [1:0]        ir_q, ir_d;
    logic              busy, half_end, rise, fall, accept;

    assign busy     = state_q != IDLE && state_q != RESP;
    assign half_end = half_q == HW'(TCK_HALF - 1);
    assign rise     = busy && half_end && !tck_q;
    assign fall     = busy && half_end && tck_q;
    assign accept   = bus.cmd_valid && state_q == IDLE;

    // A tck falling edge closes the current period, so every state change lands on one.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        tck_d   = tck_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cap_d   = cap_q;
        rsp_d   = rsp_q;
        ir_d    = ir_q;
        if (busy) begin
            half_d = half_end ? '0 : half_q + 1'b1;
            tck_d  = half_end ? !tck_q : tck_q;
        end
        if (accept) begin
            state_d = bus.cmd_ir_en ? UIR : CDR;
            shift_d = bus.cmd_data;
            ir_d    = bus.cmd_ir_en ? bus.cmd_ir : ir_q;
            half_d  = '0;
            tck_d   = 1'b0;
            bit_d   = '0;
        end
        if (rise && state_q == SDR)
            cap_d = {bus.vji_tdo, cap_q[DR_LEN-1:1]};
        if (fall) begin
            shift_d = state_q == SDR ? shift_q >> 1 : shift_q;
            bit_d   = state_q == SDR ? bit_q + 1'b1 : bit_q;
            rsp_d   = state_q == UDR ? cap_q : rsp_q;
            state_d = state_q == UIR ? CDR :
                      state_q == CDR ? SDR :
                      state_q == SDR ? (bit_q == BW'(DR_LEN - 1) ? UDR : SDR) : RESP;
        end
        if (state_q == RESP && bus.rsp_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            half_q  <= '0;
            tck_q   <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            tck_q   <= tck_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cap_q   <= cap_d;
            rsp_q   <= rsp_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_data  = rsp_q;
    assign bus.vji_tck   = tck_q;
    assign bus.vji_tdi   = state_q == SDR && shift_q[0];
    assign bus.vji_ir_in = ir_q;
    assign bus.vji_uir   = state_q == UIR;
    assign bus.vji_cdr   = state_q == CDR;
    assign bus.vji_sdr   = state_q == SDR;
    assign bus.vji_udr   = state_q == UDR;
    assign bus.vji_rti   = state_q == IDLE || state_q == RESP;
endmodule

// File: tb/tb_de1_soc_qsys_cpu_debug_host_seq.sv
// tb_de1_soc_qsys_cpu_debug_host_seq: two sequencers (TCK_HALF 1 and 3) with tdo looped back
// from tdi one tck period late, driven by directed and random commands.
module tb_de1_soc_qsys_cpu_debug_host_seq;
    localparam int DL = 38;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sel = 1'b0;
    logic          cv = 1'b0;
    logic          ien = 1'b0;
    logic          rr = 1'b0;
    logic [1:0]    cir = '0;
    logic [DL-1:0] cdata = '0;
    logic [1:0]    last_ir [2];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    de1_soc_qsys_cpu_debug_host_seq_if #(.DR_LEN(DL)) a ();
    de1_soc_qsys_cpu_debug_host_seq_if #(.DR_LEN(DL)) b ();

    de1_soc_qsys_cpu_debug_host_seq #(.DR_LEN(DL), .TCK_HALF(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(a.slave));
    de1_soc_qsys_cpu_debug_host_seq #(.DR_LEN(DL), .TCK_HALF(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(b.slave));

    assign a.cmd_valid = cv & ~sel;
    assign b.cmd_valid = cv & sel;
    assign a.rsp_ready = rr & ~sel;
    assign b.rsp_ready = rr & sel;
    assign a.cmd_ir_en = ien;
    assign b.cmd_ir_en = ien;
    assign a.cmd_ir    = cir;
    assign b.cmd_ir    = cir;
    assign a.cmd_data  = cdata;
    assign b.cmd_data  = cdata;

    // Target model: tdo presents the tdi bit seen one tck period earlier.
    logic a_hold = 1'b0, a_dly = 1'b0, b_hold = 1'b0, b_dly = 1'b0;
    always @(posedge a.vji_tck) a_hold = a.vji_tdi;
    always @(negedge a.vji_tck) a_dly = a_hold;
    always @(posedge b.vji_tck) b_hold = b.vji_tdi;
    always @(negedge b.vji_tck) b_dly = b_hold;
    assign a.vji_tdo = a_dly;
    assign b.vji_tdo = b_dly;

    wire          o_ready = sel ? b.cmd_ready : a.cmd_ready;
    wire          o_rv    = sel ? b.rsp_valid : a.rsp_valid;
    wire [DL-1:0] o_rd    = sel ? b.rsp_data  : a.rsp_data;
    wire          o_tck   = sel ? b.vji_tck   : a.vji_tck;
    wire          o_tdi   = sel ? b.vji_tdi   : a.vji_tdi;
    wire [1:0]    o_ir    = sel ? b.vji_ir_in : a.vji_ir_in;
    wire          o_uir   = sel ? b.vji_uir   : a.vji_uir;
    wire          o_cdr   = sel ? b.vji_cdr   : a.vji_cdr;
    wire          o_sdr   = sel ? b.vji_sdr   : a.vji_sdr;
    wire          o_udr   = sel ? b.vji_udr   : a.vji_udr;
    wire          o_rti   = sel ? b.vji_rti   : a.vji_rti;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DL-1:0] rnd();
        return DL'({$urandom(), $urandom()});
    endfunction

    task automatic chk_reset_vals(input logic s);
        sel = s;
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_rti", o_rti, 1);
        chk("rst_tck", o_tck, 0);
        chk("rst_valid", o_rv, 0);
        chk("rst_ir", o_ir, 0);
        chk("rst_data", o_rd, 0);
        chk("rst_tdi", o_tdi, 0);
        chk("rst_strobes", {o_uir, o_cdr, o_sdr, o_udr}, 0);
    endtask

    // One command on the selected DUT, then `hold` clk of response backpressure.
    task automatic run(input logic s, input logic ie, input logic [1:0] ir, input logic [DL-1:0] d, input int hold);
        int th, n, nu, nc, ns, nd, nr, bad_ir, bad_hot, bad_tdi, bad_bp;
        logic first_ready, first_strobe, ptck, ptdi;
        logic [DL-1:0] exp_rd, rd0;
        th = s ? 3 : 1;
        if (ie) last_ir[s] = ir;
        exp_rd = d << 1;
        @(negedge clk);
        sel = s; cv = 1'b1; ien = ie; cir = ir; cdata = d;
        #1;
        chk("ready_idle", o_ready, 1);
        @(posedge clk);
        #1 cv = 1'b0;
        n = 0; nu = 0; nc = 0; ns = 0; nd = 0; nr = 0;
        bad_ir = 0; bad_hot = 0; bad_tdi = 0;
        first_ready = 1'b1; first_strobe = 1'b0; ptck = 1'b0; ptdi = 1'b0;
        while (!o_rv && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                first_ready = o_ready;
                first_strobe = ie ? o_uir : o_cdr;
            end
            nu += int'(o_uir); nc += int'(o_cdr); ns += int'(o_sdr); nd += int'(o_udr); nr += int'(o_rti);
            if (!o_rv && o_ir !== last_ir[s]) bad_ir++;
            if (int'(o_uir) + int'(o_cdr) + int'(o_sdr) + int'(o_udr) != (o_rv ? 0 : 1)) bad_hot++;
            if (ptck && o_tck && o_tdi !== ptdi) bad_tdi++;
            ptck = o_tck; ptdi = o_tdi;
        end
        chk("latency", n, (DL + 2 + int'(ie)) * 2 * th + 1);
        chk("ready_drop", first_ready, 0);
        chk("first_strobe", first_strobe, 1);
        chk("uir_clks", nu, ie ? 2 * th : 0);
        chk("cdr_clks", nc, 2 * th);
        chk("sdr_clks", ns, DL * 2 * th);
        chk("udr_clks", nd, 2 * th);
        chk("rti_clks", nr, 1);
        chk("ir_hold", bad_ir, 0);
        chk("onehot", bad_hot, 0);
        chk("tdi_tck_high", bad_tdi, 0);
        chk("rsp_data", o_rd, exp_rd);
        chk("ir_value", o_ir, last_ir[s]);
        rd0 = o_rd; bad_bp = 0;
        cv = hold > 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_rd !== rd0 || o_ready || o_tck || !o_rv || !o_rti) bad_bp++;
        end
        cv = 1'b0; rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("backpressure", bad_bp, 0);
        chk("ready_after", o_ready, 1);
        chk("valid_after", o_rv, 0);
    endtask

    initial begin
        int n, ns, nv;
        last_ir[0] = '0;
        last_ir[1] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_reset_vals(1'b0);
        chk_reset_vals(1'b1);

        run(1'b0, 1'b1, 2'b10, 38'h2A_5A5A_5A5A, 0);
        run(1'b0, 1'b0, 2'($urandom()), rnd(), 10);
        for (int k = 0; k < 4; k++)
            run(1'b0, 1'($urandom()), 2'($urandom()), rnd(), int'($urandom_range(0, 3)));
        run(1'b1, 1'b1, 2'($urandom()), rnd(), 2);
        run(1'b1, 1'($urandom()), 2'($urandom()), rnd(), 0);

        // Reset in the middle of SDR bit 10 on the TCK_HALF=1 sequencer.
        @(negedge clk);
        sel = 1'b0; cv = 1'b1; ien = 1'b1; cir = 2'b01; cdata = rnd();
        @(posedge clk);
        #1 cv = 1'b0;
        n = 0; ns = 0;
        while (ns < 21 && n < 500) begin
            @(negedge clk);
            n++;
            ns += int'(o_sdr);
        end
        chk("reach_bit10", ns, 21);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sdr", o_sdr, 0);
        chk("mid_rst_tck", o_tck, 0);
        chk("mid_rst_rti", o_rti, 1);
        chk("mid_rst_ir", o_ir, 0);
        last_ir[0] = '0;
        last_ir[1] = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nv = 0;
        repeat (100) begin
            @(negedge clk);
            nv += int'(o_rv);
        end
        chk("no_rsp_after_rst", nv, 0);
        run(1'b0, 1'b0, 2'b11, rnd(), 1);
        run(1'b1, 1'b1, 2'b01, rnd(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
